// File: rtl/spi_master_param.sv
// Parametrised SPI master: DATA_WIDTH-bit MSB-first words, NUM_CS selects, runtime mode/divider, CS hold.
// Optional macro SPI_LOOPBACK_EN adds LoopbackRegister to feed internal MOSI back into the RX path.
module spi_master_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CS       = 1,
    parameter int DIV_WIDTH    = 8,
    parameter int CS_IDX_WIDTH = 1
) (
    input  logic                    MasterCLK,
    input  logic                    Reset,
    input  logic                    SPI_EnableRegister,
    input  logic [DIV_WIDTH-1:0]    ClockDividerRegister,
    input  logic [1:0]              ModeRegister,
    input  logic [CS_IDX_WIDTH-1:0] CS_SelectRegister,
    input  logic                    CS_HoldRegister,
    input  logic                    EnableDataWriteRegister,
    input  logic [DATA_WIDTH-1:0]   OutputDataRegister,
`ifdef SPI_LOOPBACK_EN
    input  logic                    LoopbackRegister,
`endif
    input  logic                    SPI_MISO,
    output logic                    BussyDataWriteRegister,
    output logic                    EnableDataReadRegister,
    output logic [DATA_WIDTH-1:0]   InputDataRegister,
    output logic                    SPI_CLK,
    output logic [NUM_CS-1:0]       SPI_CS,
    output logic                    SPI_MOSI
);

    localparam int EDGE_W = $clog2(2 * DATA_WIDTH);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH - 1);
    localparam logic [CS_IDX_WIDTH:0] CS_LIMIT = (CS_IDX_WIDTH + 1)'(NUM_CS);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t                  state_reg;
    logic [DIV_WIDTH-1:0]    cnt_reg;
    logic [DIV_WIDTH-1:0]    div_reg;
    logic [EDGE_W-1:0]       edge_reg;
    logic [DATA_WIDTH-1:0]   tx_reg;
    logic [DATA_WIDTH-1:0]   rx_reg;
    logic [DATA_WIDTH-1:0]   rd_data_reg;
    logic                    cpol_reg;
    logic                    cpha_reg;
    logic [NUM_CS-1:0]       sel_reg;
    logic [NUM_CS-1:0]       cs_reg;
    logic                    sclk_reg;
    logic                    mosi_reg;
    logic                    busy_reg;
    logic                    rd_pulse_reg;

    logic [NUM_CS-1:0]       sel_mask;
    logic                    cs_valid;
    logic                    tick;
    logic                    sample_edge;
    logic                    rx_bit;

    // Active-low one-hot decode of the requested slave index.
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_sel
        assign sel_mask[gi] = ({1'b0, CS_SelectRegister} != (CS_IDX_WIDTH + 1)'(gi));
    end

    assign cs_valid = ({1'b0, CS_SelectRegister} < CS_LIMIT);
    assign tick     = (cnt_reg == '0);
    // edge_reg counts completed edges, so an even count means the upcoming edge is odd.
    assign sample_edge = (~edge_reg[0]) ^ cpha_reg;

`ifdef SPI_LOOPBACK_EN
    assign rx_bit = LoopbackRegister ? mosi_reg : SPI_MISO;
`else
    assign rx_bit = SPI_MISO;
`endif

    always_ff @(posedge MasterCLK or posedge Reset) begin
        if (Reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            div_reg      <= '0;
            edge_reg     <= '0;
            tx_reg       <= '0;
            rx_reg       <= '0;
            rd_data_reg  <= '0;
            cpol_reg     <= 1'b0;
            cpha_reg     <= 1'b0;
            sel_reg      <= '1;
            cs_reg       <= '1;
            sclk_reg     <= 1'b0;
            mosi_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            rd_pulse_reg <= 1'b0;
        end else begin
            rd_pulse_reg <= 1'b0;
            if (!SPI_EnableRegister) begin
                state_reg <= IDLE;
                cs_reg    <= '1;
                sclk_reg  <= cpol_reg;
                mosi_reg  <= 1'b1;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        mosi_reg <= 1'b1;
                        sclk_reg <= ModeRegister[1];
                        cpol_reg <= ModeRegister[1];
                        if (EnableDataWriteRegister && cs_valid) begin
                            state_reg <= SETUP;
                            busy_reg  <= 1'b1;
                            tx_reg    <= OutputDataRegister;
                            cpha_reg  <= ModeRegister[0];
                            div_reg   <= ClockDividerRegister;
                            cnt_reg   <= ClockDividerRegister;
                            edge_reg  <= '0;
                            sel_reg   <= sel_mask;
                            // A CS held low for another slave is released for one cycle first.
                            cs_reg    <= (cs_reg != '1 && cs_reg != sel_mask) ? '1 : sel_mask;
                            if (!ModeRegister[0]) begin
                                mosi_reg <= OutputDataRegister[DATA_WIDTH-1];
                            end
                        end else if (!CS_HoldRegister) begin
                            cs_reg <= '1;
                        end
                    end
                    SETUP: begin
                        cs_reg <= sel_reg;
                        if (tick) begin
                            cnt_reg   <= div_reg;
                            state_reg <= SHIFT;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (tick) begin
                            cnt_reg  <= div_reg;
                            sclk_reg <= ~sclk_reg;
                            edge_reg <= edge_reg + 1'b1;
                            if (sample_edge) begin
                                rx_reg <= {rx_reg[DATA_WIDTH-2:0], rx_bit};
                            end else if (cpha_reg) begin
                                mosi_reg <= tx_reg[DATA_WIDTH-1];
                                tx_reg   <= tx_reg << 1;
                            end else begin
                                mosi_reg <= (edge_reg == LAST_EDGE) ? 1'b1 : tx_reg[DATA_WIDTH-2];
                                tx_reg   <= tx_reg << 1;
                            end
                            if (edge_reg == LAST_EDGE) begin
                                state_reg <= HOLD;
                            end
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                    HOLD: begin
                        if (tick) begin
                            if (!CS_HoldRegister) begin
                                cs_reg <= '1;
                            end
                            state_reg <= DONE;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                    DONE: begin
                        state_reg    <= IDLE;
                        busy_reg     <= 1'b0;
                        rd_data_reg  <= rx_reg;
                        rd_pulse_reg <= 1'b1;
                        mosi_reg     <= 1'b1;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign BussyDataWriteRegister = busy_reg;
    assign EnableDataReadRegister = rd_pulse_reg;
    assign InputDataRegister      = rd_data_reg;
    assign SPI_CLK                = sclk_reg;
    assign SPI_CS                 = cs_reg;
    assign SPI_MOSI               = mosi_reg;

endmodule
